icap_scheduler: RTL and testbench

Shares the single Spartan-6 ICAP port between two command requesters and paces every ICAP access to a programmable slot rate. Requester 0 is the multiboot reboot sequencer, which issues IPROG word bursts. Requester 1 is the ZX-UNO register-side configuration access path, used for BOOTSTS/GENERAL register readback and writes. The block sits between those requesters and the bit-swapping ICAP wrapper. It owns burst arbitration, slot timing and read-data capture.

---
 rtl/icap_scheduler.sv | 146 ++++++++++++++
 tb/tb_icap_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_scheduler.sv
// Arbitrates two command requesters onto the single ICAP port and paces every
// access to one slot per DIV clk cycles, capturing read data after RD_LAT slots.
module icap_scheduler #(
  parameter int DIV    = 2,
  parameter int RD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [15:0] r0_data,
  input  logic        r0_rd,
  input  logic        r0_last,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [15:0] r1_data,
  input  logic        r1_rd,
  input  logic        r1_last,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        rowner,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        icap_ce_n,
  output logic        icap_write_n,
  output logic [15:0] icap_i,
  input  logic [15:0] icap_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  // Handshake: a requester holds valid and payload stable until ready; the
  // word transfers on the cycle where valid && ready. ready depends only on
  // state, tick and grant, never on valid.
  typedef enum logic [1:0] {IDLE, BURST, RDWAIT, GAP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    grant_nx;
  logic [2:0]    rdcnt, rdcnt_nx;
  logic          rd_last, rd_last_nx;
  logic          ce_nx, we_nx, cap;
  logic [15:0]   i_nx;
  logic          own_valid, own_rd, own_last;
  logic [15:0]   own_data;

  assign tick = (cnt == CW'(DIV - 1));
  assign busy = (state != IDLE);

  assign r0_ready = tick && (state == BURST) && grant[0];
  assign r1_ready = tick && (state == BURST) && grant[1];

  assign own_valid = grant[1] ? r1_valid : r0_valid;
  assign own_data  = grant[1] ? r1_data  : r0_data;
  assign own_rd    = grant[1] ? r1_rd    : r0_rd;
  assign own_last  = grant[1] ? r1_last  : r0_last;

  // Next-slot values; they are only committed on a tick edge.
  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    rdcnt_nx   = rdcnt;
    rd_last_nx = rd_last;
    ce_nx      = 1'b1;
    we_nx      = 1'b1;
    i_nx       = 16'hFFFF;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        if (r0_valid) begin
          grant_nx = 2'b01;
          state_nx = BURST;
        end else if (r1_valid) begin
          grant_nx = 2'b10;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (own_valid) begin
          ce_nx = 1'b0;
          if (own_rd) begin
            rdcnt_nx   = 3'(RD_LAT);
            rd_last_nx = own_last;
            state_nx   = RDWAIT;
          end else begin
            we_nx = 1'b0;
            i_nx  = own_data;
            if (own_last) state_nx = GAP;
          end
        end
      end
      RDWAIT: begin
        // RD_LAT read slots follow the read word; the slot after them captures.
        if (rdcnt == 3'd0) begin
          cap      = 1'b1;
          state_nx = rd_last ? GAP : BURST;
        end else begin
          ce_nx    = 1'b0;
          rdcnt_nx = rdcnt - 3'd1;
        end
      end
      GAP: begin
        grant_nx = 2'b00;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      state        <= IDLE;
      grant        <= 2'b00;
      rdcnt        <= 3'd0;
      rd_last      <= 1'b0;
      icap_ce_n    <= 1'b1;
      icap_write_n <= 1'b1;
      icap_i       <= 16'hFFFF;
      rdata        <= 16'h0000;
      rvalid       <= 1'b0;
      rowner       <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      if (tick) begin
        cnt          <= '0;
        state        <= state_nx;
        grant        <= grant_nx;
        rdcnt        <= rdcnt_nx;
        rd_last      <= rd_last_nx;
        icap_ce_n    <= ce_nx;
        icap_write_n <= we_nx;
        icap_i       <= i_nx;
        if (cap) begin
          rdata  <= icap_o;
          rvalid <= 1'b1;
          rowner <= grant[1];
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icap_scheduler.sv
// Directed bench for icap_scheduler (DIV=2, RD_LAT=3): every clk cycle of the
// ICAP-side outputs is logged and compared against hand-built slot sequences.
module tb_icap_scheduler;

  localparam int W = 21;  // {rvalid, grant[1:0], ce_n, write_n, icap_i[15:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_rd, r0_last;
  logic [15:0] r0_data;
  logic        r1_valid, r1_ready, r1_rd, r1_last;
  logic [15:0] r1_data;
  logic [15:0] rdata;
  logic        rvalid, rowner, busy;
  logic [1:0]  grant;
  logic        icap_ce_n, icap_write_n;
  logic [15:0] icap_i, icap_o;

  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  logic [15:0] iprog [14] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h30A1, 16'h0000,
                              16'h3261, 16'h8000, 16'h3281, 16'h6B05, 16'h3301,
                              16'h3100, 16'h30A1, 16'h000E, 16'h2000};

  icap_scheduler #(.DIV(2), .RD_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data),
    .r0_rd(r0_rd), .r0_last(r0_last),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data),
    .r1_rd(r1_rd), .r1_last(r1_last),
    .rdata(rdata), .rvalid(rvalid), .rowner(rowner), .grant(grant), .busy(busy),
    .icap_ce_n(icap_ce_n), .icap_write_n(icap_write_n),
    .icap_i(icap_i), .icap_o(icap_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) obs_q.push_back({rvalid, grant, icap_ce_n, icap_write_n, icap_i});

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $display("FAIL %s got %h want %h", tag, got, want);
      $error("check %s", tag);
    end
  endtask

  task automatic exp_push(input logic rv, input logic [1:0] g, input logic ce,
                          input logic we, input logic [15:0] d, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({rv, g, ce, we, d});
  endtask

  task automatic exp_idle(input logic [1:0] g, input int n);
    exp_push(1'b0, g, 1'b1, 1'b1, 16'hFFFF, n);
  endtask

  task automatic check_log(input string tag);
    tests++;
    assert (obs_q.size() >= exp_q.size()) else begin
      fails++;
      $display("FAIL %s_len got %0d want %0d", tag, obs_q.size(), exp_q.size());
      $error("check %s_len", tag);
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      assert (obs_q[k] === exp_q[k]) else begin
        fails++;
        $display("FAIL %s[%0d] got %h want %h", tag, k, obs_q[k], exp_q[k]);
        $error("check %s", tag);
      end
    end
    exp_q.delete();
  endtask

  task automatic send0(input logic [15:0] d, input logic rd, input logic last);
    int n = 0;
    r0_valid = 1'b1; r0_data = d; r0_rd = rd; r0_last = last;
    forever begin
      @(negedge clk);
      if (r0_ready) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL r0_ready_timeout got 0 want 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    r0_valid = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d, input logic rd, input logic last);
    int n = 0;
    r1_valid = 1'b1; r1_data = d; r1_rd = rd; r1_last = last;
    forever begin
      @(negedge clk);
      if (r1_ready) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL r1_ready_timeout got 0 want 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    r1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    r0_valid = 1'b0; r0_data = '0; r0_rd = 1'b0; r0_last = 1'b0;
    r1_valid = 1'b0; r1_data = '0; r1_rd = 1'b0; r1_last = 1'b0;
    icap_o = 16'h0000;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset values
    check("rst_ce_n", 32'(icap_ce_n), 32'd1);
    check("rst_write_n", 32'(icap_write_n), 32'd1);
    check("rst_icap_i", 32'(icap_i), 32'hFFFF);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rowner", 32'(rowner), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'({r0_ready, r1_ready}), 32'd0);

    // 14-word IPROG burst on r0: no bubbles, then idle with grant dropped
    do_reset();
    exp_idle(2'b00, 2);
    exp_idle(2'b01, 2);
    for (int k = 0; k < 14; k++) exp_push(1'b0, 2'b01, 1'b0, 1'b0, iprog[k], 2);
    exp_idle(2'b00, 4);
    for (int k = 0; k < 14; k++) send0(iprog[k], 1'b0, k == 13);
    repeat (8) @(posedge clk);
    check_log("iprog");

    // Simultaneous requests: r0 wins, r1 follows after gap and grant slot
    do_reset();
    exp_idle(2'b00, 2);
    exp_idle(2'b01, 2);
    exp_push(1'b0, 2'b01, 1'b0, 1'b0, 16'hA001, 2);
    exp_push(1'b0, 2'b01, 1'b0, 1'b0, 16'hA002, 2);
    exp_idle(2'b00, 2);
    exp_idle(2'b10, 2);
    exp_push(1'b0, 2'b10, 1'b0, 1'b0, 16'hB001, 2);
    exp_push(1'b0, 2'b10, 1'b0, 1'b0, 16'hB002, 2);
    exp_idle(2'b00, 4);
    fork
      begin send0(16'hA001, 1'b0, 1'b0); send0(16'hA002, 1'b0, 1'b1); end
      begin send1(16'hB001, 1'b0, 1'b0); send1(16'hB002, 1'b0, 1'b1); end
    join
    repeat (8) @(posedge clk);
    check_log("same_cycle");

    // r0 arrives during r1's 3rd word; r1 burst is not preempted
    do_reset();
    exp_idle(2'b00, 2);
    exp_idle(2'b10, 2);
    for (int k = 0; k < 5; k++) exp_push(1'b0, 2'b10, 1'b0, 1'b0, 16'hC100 + 16'(k), 2);
    exp_idle(2'b00, 2);
    exp_idle(2'b01, 2);
    exp_push(1'b0, 2'b01, 1'b0, 1'b0, 16'hC001, 2);
    exp_idle(2'b00, 4);
    fork
      for (int k = 0; k < 5; k++) send1(16'hC100 + 16'(k), 1'b0, k == 4);
      begin repeat (9) @(posedge clk); #1; send0(16'hC001, 1'b0, 1'b1); end
    join
    repeat (8) @(posedge clk);
    check_log("no_preempt");

    // r1 write then read-with-last: rvalid 8 clk after the read slot
    do_reset();
    icap_o = 16'h1234;
    exp_idle(2'b00, 2);
    exp_idle(2'b10, 2);
    exp_push(1'b0, 2'b10, 1'b0, 1'b0, 16'h2901, 2);
    exp_push(1'b0, 2'b10, 1'b0, 1'b1, 16'hFFFF, 8);
    exp_push(1'b1, 2'b10, 1'b1, 1'b1, 16'hFFFF, 1);
    exp_idle(2'b10, 1);
    exp_idle(2'b00, 4);
    send1(16'h2901, 1'b0, 1'b0);
    send1(16'h0000, 1'b1, 1'b1);
    check("rdwait_busy", 32'(busy), 32'd1);
    check("rdwait_grant", 32'(grant), 32'h2);
    repeat (16) @(posedge clk);
    check_log("read");
    check("read_rdata", 32'(rdata), 32'h1234);
    check("read_rowner", 32'(rowner), 32'd1);
    icap_o = 16'h0000;

    // r1 valid drops for two slots: idle slots with grant held
    do_reset();
    exp_idle(2'b00, 2);
    exp_idle(2'b10, 2);
    exp_push(1'b0, 2'b10, 1'b0, 1'b0, 16'hD001, 2);
    exp_idle(2'b10, 4);
    exp_push(1'b0, 2'b10, 1'b0, 1'b0, 16'hD002, 2);
    exp_push(1'b0, 2'b10, 1'b0, 1'b0, 16'hD003, 2);
    exp_idle(2'b00, 4);
    send1(16'hD001, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    send1(16'hD002, 1'b0, 1'b0);
    send1(16'hD003, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    check_log("bubble");

    // Reset mid-burst abandons the sequence; a fresh burst starts cleanly
    do_reset();
    r0_valid = 1'b1; r0_data = 16'h1111; r0_rd = 1'b0; r0_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_icap_i", 32'(icap_i), 32'h1111);
    check("mid_ce_n", 32'(icap_ce_n), 32'd0);
    r0_valid = 1'b0;
    do_reset();
    check("rst2_ce_n", 32'(icap_ce_n), 32'd1);
    check("rst2_write_n", 32'(icap_write_n), 32'd1);
    check("rst2_icap_i", 32'(icap_i), 32'hFFFF);
    check("rst2_grant", 32'(grant), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    exp_idle(2'b00, 2);
    exp_idle(2'b01, 2);
    exp_push(1'b0, 2'b01, 1'b0, 1'b0, 16'hE001, 2);
    exp_push(1'b0, 2'b01, 1'b0, 1'b0, 16'hE002, 2);
    exp_idle(2'b00, 4);
    send0(16'hE001, 1'b0, 1'b0);
    send0(16'hE002, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    check_log("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
